// File: rtl/extensor_arbiter.sv
// extensor_arbiter: two-requester round-robin arbiter feeding one shared 16->32 sign/zero extender
module extensor_arbiter #(
  parameter logic FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  input  logic        req0_zext,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  input  logic        req1_zext,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_id,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);
  logic        ptr_q, ptr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_id_q, out_id_d;
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic        slot_free, gnt0, gnt1, sel_zext;
  logic [15:0] sel_data;
  logic [31:0] ext;
  // grant arbitration, shared extender and next-state selection
  always_comb begin
    slot_free   = ~out_valid_q | out_ready;
    gnt0        = slot_free & req0_valid & (~req1_valid | ~ptr_q);
    gnt1        = slot_free & req1_valid & (~req0_valid | ptr_q);
    sel_data    = gnt1 ? req1_data : req0_data;
    sel_zext    = gnt1 ? req1_zext : req0_zext;
    ext         = sel_zext ? {16'h0000, sel_data} : {{16{sel_data[15]}}, sel_data};
    out_valid_d = (gnt0 | gnt1) ? 1'b1 : slot_free ? 1'b0 : out_valid_q;
    out_data_d  = (gnt0 | gnt1) ? ext : out_data_q;
    out_id_d    = (gnt0 | gnt1) ? gnt1 : out_id_q;
    ptr_d       = gnt0 ? 1'b1 : gnt1 ? 1'b0 : ptr_q;
    cnt0_d      = (gnt0 && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
    cnt1_d      = (gnt1 && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
  end
  // state registers; reset discards any pending result without waiting for clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= FIRST;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      out_id_q    <= 1'b0;
      cnt0_q      <= 16'h0;
      cnt1_q      <= 16'h0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end
  assign req0_ready = gnt0 & ~reset;
  assign req1_ready = gnt1 & ~reset;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;
endmodule

// File: tb/tb_extensor_arbiter.sv
// tb_extensor_arbiter: scoreboard bench for the round-robin extender arbiter
module tb_extensor_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_zext, req1_valid, req1_zext, out_ready;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, out_valid, out_id;
  logic [31:0] out_data;
  logic [15:0] cnt0, cnt1;
  logic        b_req0_ready, b_req1_ready, b_out_valid, b_out_id;
  logic [31:0] b_out_data;
  logic [15:0] b_cnt0, b_cnt1;
  logic [32:0] sb[$];
  int          checks = 0;
  int          failures = 0;

  extensor_arbiter #(.FIRST(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_zext(req0_zext), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_zext(req1_zext), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  extensor_arbiter #(.FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_zext(req0_zext), .req0_ready(b_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_zext(req1_zext), .req1_ready(b_req1_ready),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_id(b_out_id),
    .cnt0(b_cnt0), .cnt1(b_cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [15:0] d, input logic z);
    return z ? {16'h0000, d} : {{16{d[15]}}, d};
  endfunction

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic v0, input logic [15:0] d0, input logic z0,
                      input logic v1, input logic [15:0] d1, input logic z1,
                      input logic ordy, input logic e0, input logic e1);
    req0_valid = v0; req0_data = d0; req0_zext = z0;
    req1_valid = v1; req1_data = d1; req1_zext = z1;
    out_ready  = ordy;
    @(negedge clk);
    chk("req0_ready", {32'h0, req0_ready}, {32'h0, e0});
    chk("req1_ready", {32'h0, req1_ready}, {32'h0, e1});
    if (e0) sb.push_back({1'b0, ext(d0, z0)});
    if (e1) sb.push_back({1'b1, ext(d1, z1)});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL result unexpected actual=%h required=none", {out_id, out_data});
      end else begin
        chk("result", {out_id, out_data}, sb.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h8001; req0_zext = 1'b0;
    req1_valid = 1'b1; req1_data = 16'h8001; req1_zext = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", {32'h0, out_valid}, 33'h0);
    chk("rst_out_data", {1'b0, out_data}, 33'h0);
    chk("rst_out_id", {32'h0, out_id}, 33'h0);
    chk("rst_cnts", {1'b0, cnt0, cnt1}, 33'h0);
    @(posedge clk);
    #1;
    chk("rst_readies", {31'h0, req0_ready, req1_ready}, 33'h0);
    reset = 1'b0;
    // basic extension
    step(1, 16'h8001, 0, 0, 16'h0000, 0, 1, 1, 0);
    chk("sext_data", {1'b0, out_data}, {1'b0, 32'hFFFF8001});
    chk("sext_id_valid", {31'h0, out_id, out_valid}, 33'h1);
    step(0, 16'h0000, 0, 1, 16'h8001, 1, 1, 0, 1);
    chk("zext_data", {1'b0, out_data}, {1'b0, 32'h00008001});
    step(0, 16'h0000, 0, 1, 16'h7FFF, 0, 1, 0, 1);
    step(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0);
    chk("idle_valid", {32'h0, out_valid}, 33'h0);
    chk("idle_hold", {out_id, out_data}, {1'b1, 32'h00007FFF});
    // backpressure: pointer at 0 -> req0 wins, then pointer at 1
    step(1, 16'h1234, 0, 1, 16'hF00F, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h5555, 1, 1, 16'hF00F, 0, 0, 0, 0);
      chk("stall_hold", {out_id, out_data}, {1'b0, 32'h00001234});
      chk("stall_valid", {32'h0, out_valid}, 33'h1);
    end
    step(1, 16'h5555, 1, 1, 16'hF00F, 0, 1, 0, 1);
    chk("bp_new_data", {out_id, out_data}, {1'b1, 32'hFFFFF00F});
    // fairness with same-cycle drain/refill
    for (int i = 0; i < 8; i++)
      step(1, 16'h1234, 0, 1, 16'hF00F, 0, 1, (i % 2) == 0, (i % 2) == 1);
    chk("fair_cnts", {1'b0, cnt0, cnt1}, {1'b0, 16'd6, 16'd7});
    // asynchronous reset mid-transfer
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", {32'h0, out_valid}, 33'h0);
    chk("async_cnts", {1'b0, cnt0, cnt1}, 33'h0);
    chk("async_data", {out_id, out_data}, 33'h0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0_valid = 1; req0_data = 16'h0001; req0_zext = 1;
    req1_valid = 1; req1_data = 16'h0002; req1_zext = 1;
    out_ready = 1;
    @(negedge clk);
    chk("post_rst_first0", {31'h0, req0_ready, req1_ready}, 33'h2);
    chk("post_rst_first1", {31'h0, b_req0_ready, b_req1_ready}, 33'h1);
    sb.push_back({1'b0, 32'h00000001});
    @(posedge clk);
    #1;
    chk("post_rst_data", {out_id, out_data}, {1'b0, 32'h00000001});
    // saturation
    reset = 1'b1;
    #1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 65535; i++)
      step(1, 16'(i), i[0], 0, 16'h0000, 0, 1, 1, 0);
    chk("sat_cnt0", {17'h0, cnt0}, {17'h0, 16'hFFFF});
    chk("sat_cnt1", {17'h0, cnt1}, 33'h0);
    for (int i = 0; i < 2; i++)
      step(1, 16'hC000, 0, 0, 16'h0000, 0, 1, 1, 0);
    chk("sat_hold", {1'b0, cnt0, cnt1}, {1'b0, 16'hFFFF, 16'h0000});
    step(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0);
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_empty", 33'(sb.size()), 33'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
